// File: rtl/usr_cmd_sequencer.sv
// Command front-end for the 4-bit universal shift register; optional rotate feature via USR_SEQ_ROTATE_EN.
// Latency: outputs change the cycle after accept; RUN lasts len cycles (1 for load or len=0), done on the last.
// Backpressure: cmd_ready is high only in IDLE; a command held valid during RUN waits for the return to IDLE.
module usr_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] cmd_data,
`ifdef USR_SEQ_ROTATE_EN
   input  logic             cmd_rot,
   input  logic [WIDTH-1:0] usr_q,
`endif
   output logic [1:0]       ctrl,
   output logic             serial_in_left,
   output logic             serial_in_right,
   output logic [WIDTH-1:0] parallel_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [1:0] OP_HOLD  = 2'b00;
   localparam logic [1:0] OP_RIGHT = 2'b01;
   localparam logic [1:0] OP_LEFT  = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sil_r;
   logic             sir_r;
   logic             is_load;
   logic             len_zero;
   logic [CNT_W-1:0] len_eff;

   // Load and zero-length commands collapse to a single RUN cycle.
   assign is_load  = (cmd_op == OP_LOAD);
   assign len_zero = (cmd_len == '0);
   assign len_eff  = (is_load || len_zero) ? CNT_W'(1) : cmd_len;

`ifdef USR_SEQ_ROTATE_EN
   logic rot_l_r;
   logic rot_r_r;

   // Rotate feeds the shift register's own end bit back in, so it must be combinational.
   assign serial_in_left  = rot_l_r ? usr_q[0]       : sil_r;
   assign serial_in_right = rot_r_r ? usr_q[WIDTH-1] : sir_r;
`else
   assign serial_in_left  = sil_r;
   assign serial_in_right = sir_r;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ctrl        <= OP_HOLD;
         sil_r       <= 1'b0;
         sir_r       <= 1'b0;
         parallel_in <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cmd_ready   <= 1'b1;
`ifdef USR_SEQ_ROTATE_EN
         rot_l_r     <= 1'b0;
         rot_r_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state       <= RUN;
                  cnt         <= len_eff;
                  ctrl        <= is_load ? OP_LOAD : (len_zero ? OP_HOLD : cmd_op);
                  parallel_in <= cmd_data;
                  busy        <= 1'b1;
                  done        <= (len_eff == CNT_W'(1));
                  cmd_ready   <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
                  sil_r       <= (cmd_op == OP_RIGHT) && !cmd_rot && cmd_fill;
                  sir_r       <= (cmd_op == OP_LEFT)  && !cmd_rot && cmd_fill;
                  rot_l_r     <= (cmd_op == OP_RIGHT) && cmd_rot;
                  rot_r_r     <= (cmd_op == OP_LEFT)  && cmd_rot;
`else
                  sil_r       <= (cmd_op == OP_RIGHT) && cmd_fill;
                  sir_r       <= (cmd_op == OP_LEFT)  && cmd_fill;
`endif
               end
            end
            RUN: begin
               if (cnt <= CNT_W'(1)) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  ctrl        <= OP_HOLD;
                  sil_r       <= 1'b0;
                  sir_r       <= 1'b0;
                  parallel_in <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b0;
                  cmd_ready   <= 1'b1;
`ifdef USR_SEQ_ROTATE_EN
                  rot_l_r     <= 1'b0;
                  rot_r_r     <= 1'b0;
`endif
               end else begin
                  cnt  <= cnt - CNT_W'(1);
                  done <= (cnt == CNT_W'(2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer driving a behavioural 4-bit universal shift register.
module tb_usr_cmd_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic             cmd_fill;
   logic [WIDTH-1:0] cmd_data;
   logic [1:0]       ctrl;
   logic             serial_in_left;
   logic             serial_in_right;
   logic [WIDTH-1:0] parallel_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sr_q;
`ifdef USR_SEQ_ROTATE_EN
   logic             cmd_rot;
`endif

   always #5 clk = ~clk;

   usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
`ifdef USR_SEQ_ROTATE_EN
      .cmd_rot(cmd_rot), .usr_q(sr_q),
`endif
      .ctrl(ctrl), .serial_in_left(serial_in_left), .serial_in_right(serial_in_right),
      .parallel_in(parallel_in), .busy(busy), .done(done)
   );

   // The downstream universal shift register.
   always @(posedge clk) begin
      if (reset) sr_q <= '0;
      else case (ctrl)
         2'b01:   sr_q <= {serial_in_left, sr_q[WIDTH-1:1]};
         2'b10:   sr_q <= {sr_q[WIDTH-2:0], serial_in_right};
         2'b11:   sr_q <= parallel_in;
         default: ;
      endcase
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0] op; logic [2:0] len; logic fill; logic [3:0] data;
      int n; logic [1:0] ctrl; logic sil; logic sir; logic [3:0] out;
   } vec_t;
   vec_t tbl[7];

   typedef struct packed {
      logic ready; logic busy; logic done; logic [1:0] ctrl;
      logic sil; logic sir; logic [3:0] pin;
   } obs_t;
   obs_t exp_q[$];
   localparam obs_t IDLE_OBS = '{ready: 1'b1, busy: 1'b0, done: 1'b0, ctrl: 2'b00,
                                 sil: 1'b0, sir: 1'b0, pin: 4'b0000};

   task automatic check_idle(input string name);
      check({name, "_ready"}, 32'(cmd_ready), 32'd1);
      check({name, "_busy"},  32'(busy),      32'd0);
      check({name, "_done"},  32'(done),      32'd0);
      check({name, "_ctrl"},  32'(ctrl),      32'd0);
      check({name, "_pin"},   32'(parallel_in), 32'd0);
   endtask

   initial begin
      obs_t act, exp;
      logic idle_now, accepted_prev;
      int   n;

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_fill = 1'b0; cmd_data = '0;
`ifdef USR_SEQ_ROTATE_EN
      cmd_rot = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset_sil", 32'(serial_in_left), 32'd0);
      check("reset_sir", 32'(serial_in_right), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      //          op     len   fill  data     n  ctrl   sil   sir   out
      tbl[0] = '{2'b11, 3'd5, 1'b0, 4'b1010, 1, 2'b11, 1'b0, 1'b0, 4'b1010};
      tbl[1] = '{2'b11, 3'd0, 1'b0, 4'b0000, 1, 2'b11, 1'b0, 1'b0, 4'b0000};
      tbl[2] = '{2'b01, 3'd3, 1'b1, 4'b0000, 3, 2'b01, 1'b1, 1'b0, 4'b1110};
      tbl[3] = '{2'b10, 3'd0, 1'b1, 4'b0101, 1, 2'b00, 1'b0, 1'b1, 4'b1110};
      tbl[4] = '{2'b10, 3'd2, 1'b0, 4'b0011, 2, 2'b10, 1'b0, 1'b0, 4'b1000};
      tbl[5] = '{2'b00, 3'd7, 1'b1, 4'b1111, 7, 2'b00, 1'b0, 1'b0, 4'b1000};
      tbl[6] = '{2'b10, 3'd1, 1'b1, 4'b0000, 1, 2'b10, 1'b0, 1'b1, 4'b0001};

      for (int k = 0; k < 7; k++) begin
         cmd_op = tbl[k].op; cmd_len = tbl[k].len; cmd_fill = tbl[k].fill;
         cmd_data = tbl[k].data; cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
         for (int i = 1; i <= tbl[k].n; i++) begin
            check($sformatf("vec%0d_c%0d_ctrl", k, i), 32'(ctrl), 32'(tbl[k].ctrl));
            check($sformatf("vec%0d_c%0d_sil", k, i), 32'(serial_in_left), 32'(tbl[k].sil));
            check($sformatf("vec%0d_c%0d_sir", k, i), 32'(serial_in_right), 32'(tbl[k].sir));
            check($sformatf("vec%0d_c%0d_pin", k, i), 32'(parallel_in), 32'(tbl[k].data));
            check($sformatf("vec%0d_c%0d_busy", k, i), 32'(busy), 32'd1);
            check($sformatf("vec%0d_c%0d_ready", k, i), 32'(cmd_ready), 32'd0);
            check($sformatf("vec%0d_c%0d_done", k, i), 32'(done), 32'(i == tbl[k].n));
            @(negedge clk);
         end
         check_idle($sformatf("vec%0d_after", k));
         check($sformatf("vec%0d_out", k), 32'(sr_q), 32'(tbl[k].out));
      end

      // Reset in the second RUN cycle aborts the command without a done pulse.
      cmd_op = 2'b01; cmd_len = 3'd4; cmd_fill = 1'b1; cmd_data = 4'h0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("abort_run1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("abort_run2_done", 32'(done), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("abort");
      @(negedge clk);
      check("abort_later_done", 32'(done), 32'd0);

      // A command presented during RUN waits until IDLE, then is taken.
      cmd_op = 2'b00; cmd_len = 3'd2; cmd_data = 4'h0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_op = 2'b11; cmd_data = 4'b0110;
      check("held_run1_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("held_run2_done", 32'(done), 32'd1);
      check("held_run2_ctrl", 32'(ctrl), 32'd0);
      @(negedge clk);
      check_idle("held_gap");
      @(negedge clk);
      cmd_valid = 1'b0;
      check("held_load_ctrl", 32'(ctrl), 32'd3);
      check("held_load_done", 32'(done), 32'd1);
      @(negedge clk);
      check("held_load_out", 32'(sr_q), 32'b0110);

`ifdef USR_SEQ_ROTATE_EN
      // Rotate left: load 1001, rotate once -> 0011; reload and rotate four times -> 1001.
      for (int r = 0; r < 2; r++) begin
         cmd_op = 2'b11; cmd_data = 4'b1001; cmd_len = 3'd1; cmd_rot = 1'b0; cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
         @(negedge clk);
         cmd_op = 2'b10; cmd_len = (r == 0) ? 3'd1 : 3'd4; cmd_fill = 1'b0; cmd_rot = 1'b1;
         cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
         check($sformatf("rot%0d_sir", r), 32'(serial_in_right), 32'd1);
         for (int w = 0; w < 8 && busy; w++) @(negedge clk);
         check($sformatf("rot%0d_out", r), 32'(sr_q), (r == 0) ? 32'b0011 : 32'b1001);
      end
      cmd_rot = 1'b0;
`endif

      // Random traffic against a per-cycle expectation queue built on each accept.
      accepted_prev = 1'b0;
      for (int c = 0; c < 800; c++) begin
         act = '{ready: cmd_ready, busy: busy, done: done, ctrl: ctrl,
                 sil: serial_in_left, sir: serial_in_right, pin: parallel_in};
         idle_now = (exp_q.size() == 0);
         exp = idle_now ? IDLE_OBS : exp_q.pop_front();
         check($sformatf("rand_cycle%0d", c), 32'(act), 32'(exp));
         if (!(cmd_valid && !accepted_prev)) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_len   = 3'($urandom_range(0, 7));
            cmd_fill  = 1'($urandom_range(0, 1));
            cmd_data  = 4'($urandom_range(0, 15));
         end
         accepted_prev = idle_now && cmd_valid;
         if (accepted_prev) begin
            n = (cmd_op == 2'b11 || cmd_len == 0) ? 1 : int'(cmd_len);
            for (int i = 1; i <= n; i++)
               exp_q.push_back('{ready: 1'b0, busy: 1'b1, done: (i == n),
                                 ctrl: (cmd_op == 2'b11) ? 2'b11 : ((cmd_len == 0) ? 2'b00 : cmd_op),
                                 sil: (cmd_op == 2'b01) && cmd_fill,
                                 sir: (cmd_op == 2'b10) && cmd_fill,
                                 pin: cmd_data});
         end
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
